// File: rtl/lsu_mem_master.sv
// lsu_mem_master: accepts one RV32 load/store at a time and drives a word-aligned pmem access.
// Stores get byte-lane wmask/wdata; loads get lane extraction with sign/zero extension.
// Build option: define MISALIGN_TRAP_EN to reject misaligned H/W accesses instead of aligning them.
module lsu_mem_master #(
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    output logic        mem_memRW,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       off_q, off_d;
    logic [2:0]       f3_q, f3_d;
    logic             wen_q, wen_d;
    logic             req_ready_q, req_ready_d;
    logic             resp_valid_q, resp_valid_d;
    logic [31:0]      resp_rdata_q, resp_rdata_d;
    logic             resp_err_q, resp_err_d;
    logic             mem_en_q, mem_en_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic [3:0]       wmask_q, wmask_d;
    logic             mem_rw_q, mem_rw_d;

    logic        is_h, is_w, bad_f3, misalign, reject;
    logic [1:0]  off;
    logic [3:0]  lane_mask;
    logic [31:0] lane_wdata;
    logic [31:0] load_lane, load_ext;

    // Decode the incoming request: legality, lane offset and right-aligned store lane
    always_comb begin
        is_h   = (req_funct3[1:0] == 2'd1);
        is_w   = (req_funct3[1:0] == 2'd2);
        bad_f3 = (req_funct3 == 3'd3) || (req_funct3[2] && (req_funct3[1] || req_wen));
`ifdef MISALIGN_TRAP_EN
        misalign = (is_h && req_addr[0]) || (is_w && (req_addr[1:0] != 2'b00));
        off      = req_addr[1:0];
`else
        misalign = 1'b0;
        off      = req_addr[1:0] & {~is_w, ~(is_h | is_w)};
`endif
        reject = bad_f3 || misalign;
        if (is_w) begin
            lane_mask  = 4'b1111;
            lane_wdata = req_wdata;
        end else if (is_h) begin
            lane_mask  = 4'b0011;
            lane_wdata = {16'h0000, req_wdata[15:0]};
        end else begin
            lane_mask  = 4'b0001;
            lane_wdata = {24'h000000, req_wdata[7:0]};
        end
    end

    // Extract and extend the addressed lane of the returned word
    always_comb begin
        load_lane = mem_rdata >> {off_q, 3'b000};
        case (f3_q)
            3'd0:    load_ext = {{24{load_lane[7]}}, load_lane[7:0]};
            3'd1:    load_ext = {{16{load_lane[15]}}, load_lane[15:0]};
            3'd4:    load_ext = {24'h000000, load_lane[7:0]};
            3'd5:    load_ext = {16'h0000, load_lane[15:0]};
            default: load_ext = load_lane;
        endcase
    end

    // Next-state and registered-output logic for IDLE -> ACCESS -> RESP -> IDLE
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        off_d        = off_q;
        f3_d         = f3_q;
        wen_d        = wen_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mem_en_d     = mem_en_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        wmask_d      = wmask_q;
        mem_rw_d     = mem_rw_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    off_d       = off;
                    f3_d        = req_funct3;
                    wen_d       = req_wen;
                    req_ready_d = 1'b0;
                    if (reject) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'h0;
                    end else begin
                        state_d     = ST_ACCESS;
                        cnt_d       = CNT_W'(MEM_LATENCY - 1);
                        mem_en_d    = 1'b1;
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                        mem_wdata_d = req_wen ? (lane_wdata << {off, 3'b000}) : 32'h0;
                        wmask_d     = req_wen ? 4'(lane_mask << off) : 4'b0000;
                        mem_rw_d    = req_wen;
                    end
                end
            end
            ST_ACCESS: begin
                // Write strobe lives only in the first access cycle
                mem_rw_d = 1'b0;
                if (cnt_q == '0) begin
                    state_d      = ST_RESP;
                    mem_en_d     = 1'b0;
                    wmask_d      = 4'b0000;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = wen_q ? 32'h0 : load_ext;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = 32'h0;
                    req_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                req_ready_d  = 1'b1;
                resp_valid_d = 1'b0;
                mem_en_d     = 1'b0;
                wmask_d      = 4'b0000;
                mem_rw_d     = 1'b0;
            end
        endcase
    end

    // State and output registers; async reset aborts any access in flight
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            off_q        <= 2'b00;
            f3_q         <= 3'd0;
            wen_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
            wmask_q      <= 4'b0000;
            mem_rw_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            off_q        <= off_d;
            f3_q         <= f3_d;
            wen_q        <= wen_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_en_q     <= mem_en_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            wmask_q      <= wmask_d;
            mem_rw_q     <= mem_rw_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_en     = mem_en_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wmask  = {4'b0000, wmask_q};
    assign mem_memRW  = mem_rw_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench for lsu_mem_master: directed store/load lanes, rejects, alignment,
// response back-pressure, random back-to-back traffic and reset during an access.
module tb_lsu_mem_master;

    localparam int unsigned LAT = 3;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wen = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_memRW;
    logic [31:0] mem_rdata = 32'h0;

    always #5 clock = ~clock;

    lsu_mem_master #(.MEM_LATENCY(LAT)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_memRW(mem_memRW), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        logic        acc;
        logic [31:0] maddr;
        logic [7:0]  wmask;
        logic [31:0] wdata;
        int          rw;
    } exp_t;

    typedef struct {
        int          lat;
        int          en_cyc;
        int          rw_cyc;
        logic [31:0] maddr;
        logic [31:0] wdata;
        logic [7:0]  wmask;
        logic [31:0] rdata;
        logic        err;
        bit          timeout;
        int          stray;
        int          hold_bad;
        logic        ready_after;
    } obs_t;

    typedef struct {
        logic        wen;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic [31:0] x_rdata;
        logic [31:0] x_maddr;
        logic [7:0]  x_wmask;
        logic [31:0] x_wdata;
    } vec_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: byte-wise lane placement, independent of the shift-based RTL
    function automatic exp_t model(input logic wen, input logic [2:0] f3,
                                   input logic [31:0] addr, input logic [31:0] wd,
                                   input logic [31:0] rd);
        exp_t e;
        int sz;
        int off;
        logic [31:0] v;
        e.err = 1'b0; e.rdata = 32'h0; e.acc = 1'b0; e.maddr = 32'h0;
        e.wmask = 8'h00; e.wdata = 32'h0; e.rw = 0;
        sz = (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 || (wen && (f3 == 3'd4 || f3 == 3'd5)))
            e.err = 1'b1;
`ifdef MISALIGN_TRAP_EN
        if ((int'(addr[1:0]) % sz) != 0) e.err = 1'b1;
        off = int'(addr[1:0]);
`else
        off = (int'(addr[1:0]) / sz) * sz;
`endif
        if (e.err) return e;
        e.acc   = 1'b1;
        e.maddr = {addr[31:2], 2'b00};
        if (wen) begin
            e.rw = 1;
            for (int i = 0; i < sz; i++) begin
                e.wmask[off+i] = 1'b1;
                e.wdata[8*(off+i) +: 8] = wd[8*i +: 8];
            end
        end else begin
            v = 32'h0;
            for (int i = 0; i < sz; i++) v[8*i +: 8] = rd[8*(off+i) +: 8];
            if (!f3[2] && sz < 4 && v[8*sz-1])
                for (int b = 8*sz; b < 32; b++) v[b] = 1'b1;
            e.rdata = v;
        end
        return e;
    endfunction

    // Drive one request, observe the pmem side and the response, then retire it
    task automatic run_req(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd, input int hold,
                           output obs_t o);
        int guard;
        o.lat = 0; o.en_cyc = 0; o.rw_cyc = 0; o.maddr = 32'h0; o.wdata = 32'h0;
        o.wmask = 8'h00; o.rdata = 32'h0; o.err = 1'b0; o.timeout = 1'b0;
        o.stray = 0; o.hold_bad = 0; o.ready_after = 1'b0;
        @(negedge clock);
        req_valid = 1'b1; req_wen = wen; req_funct3 = f3; req_addr = addr;
        req_wdata = wd; mem_rdata = rd; resp_ready = 1'b0;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 50) begin
            req_valid = 1'b0;
            o.timeout = 1'b1;
            return;
        end
        @(negedge clock);
        req_valid = 1'b0;
        o.lat = 1;
        while (resp_valid !== 1'b1 && o.lat < 40) begin
            if (mem_en === 1'b1) begin
                if (o.en_cyc > 0 && (mem_addr !== o.maddr || mem_wdata !== o.wdata ||
                                     mem_wmask !== o.wmask)) o.stray++;
                o.en_cyc++;
                o.maddr = mem_addr; o.wdata = mem_wdata; o.wmask = mem_wmask;
            end else if (mem_memRW !== 1'b0 || mem_wmask !== 8'h00) begin
                o.stray++;
            end
            if (mem_memRW === 1'b1) o.rw_cyc++;
            @(negedge clock);
            o.lat++;
        end
        if (resp_valid !== 1'b1) begin
            o.timeout = 1'b1;
            return;
        end
        if (mem_en !== 1'b0 || mem_memRW !== 1'b0 || mem_wmask !== 8'h00) o.stray++;
        o.rdata = resp_rdata;
        o.err   = resp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            if (resp_valid !== 1'b1 || resp_rdata !== o.rdata || resp_err !== o.err ||
                req_ready !== 1'b0) o.hold_bad++;
        end
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
        o.ready_after = req_ready;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clock);
        n_tests++;
        if (mem_en !== 1'b0 || mem_memRW !== 1'b0 || resp_valid !== 1'b0 || resp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: en=%b rw=%b rv=%b err=%b want all 0",
                     mem_en, mem_memRW, resp_valid, resp_err);
        end
        reset_n = 1'b1;
        @(negedge clock);
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 1", req_ready);
        end
        n_tests++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_wmask !== 8'h00 || resp_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: addr=%h wdata=%h wmask=%h rdata=%h want 0",
                     mem_addr, mem_wdata, mem_wmask, resp_rdata);
        end
    endtask

    task automatic test_store;
        vec_t v[3];
        obs_t o;
        exp_t e;
        v[0] = '{1'b1, 3'd2, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h8000_0004, 8'h0F, 32'hDEAD_BEEF};
        v[1] = '{1'b1, 3'd0, 32'h8000_0003, 32'h0000_00AB, 32'h0, 32'h0, 32'h8000_0000, 8'h08, 32'hAB00_0000};
        v[2] = '{1'b1, 3'd1, 32'h8000_0002, 32'hFFFF_1234, 32'h0, 32'h0, 32'h8000_0000, 8'h0C, 32'h1234_0000};
        for (int k = 0; k < 3; k++) begin
            sb_q.push_back('{1'b0, 32'h0, 1'b1, v[k].x_maddr, v[k].x_wmask, v[k].x_wdata, 1});
            run_req(v[k].wen, v[k].f3, v[k].addr, v[k].wd, v[k].rd, 0, o);
            n_tests++;
            if (o.timeout || sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL store%0d_timeout: timeout=%b queue=%0d", k, o.timeout, sb_q.size());
                continue;
            end
            e = sb_q.pop_front();
            n_tests++;
            if (o.maddr !== e.maddr || o.wmask !== e.wmask || o.wdata !== e.wdata) begin
                n_fail++;
                $display("FAIL store%0d_lane: addr=%h wmask=%h wdata=%h want %h %h %h",
                         k, o.maddr, o.wmask, o.wdata, e.maddr, e.wmask, e.wdata);
            end
            n_tests++;
            if (o.rw_cyc != e.rw || o.en_cyc != LAT || o.lat != LAT + 1 || o.stray != 0) begin
                n_fail++;
                $display("FAIL store%0d_timing: rw=%0d en=%0d lat=%0d stray=%0d want 1 %0d %0d 0",
                         k, o.rw_cyc, o.en_cyc, o.lat, o.stray, LAT, LAT + 1);
            end
            n_tests++;
            if (o.err !== e.err || o.rdata !== e.rdata || o.ready_after !== 1'b1) begin
                n_fail++;
                $display("FAIL store%0d_resp: err=%b rdata=%h ready=%b want 0 0 1",
                         k, o.err, o.rdata, o.ready_after);
            end
        end
    endtask

    task automatic test_load;
        vec_t v[5];
        obs_t o;
        exp_t e;
        v[0] = '{1'b0, 3'd0, 32'h8000_0001, 32'h0, 32'h1234_80FF, 32'hFFFF_FF80, 32'h8000_0000, 8'h00, 32'h0};
        v[1] = '{1'b0, 3'd4, 32'h8000_0001, 32'h0, 32'h1234_80FF, 32'h0000_0080, 32'h8000_0000, 8'h00, 32'h0};
        v[2] = '{1'b0, 3'd1, 32'h8000_0002, 32'h0, 32'h8001_BEEF, 32'hFFFF_8001, 32'h8000_0000, 8'h00, 32'h0};
        v[3] = '{1'b0, 3'd5, 32'h8000_0002, 32'h0, 32'h8001_BEEF, 32'h0000_8001, 32'h8000_0000, 8'h00, 32'h0};
        v[4] = '{1'b0, 3'd2, 32'h8000_000C, 32'h0, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'h8000_000C, 8'h00, 32'h0};
        for (int k = 0; k < 5; k++) begin
            sb_q.push_back('{1'b0, v[k].x_rdata, 1'b1, v[k].x_maddr, 8'h00, 32'h0, 0});
            run_req(v[k].wen, v[k].f3, v[k].addr, v[k].wd, v[k].rd, 0, o);
            n_tests++;
            if (o.timeout || sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL load%0d_timeout: timeout=%b queue=%0d", k, o.timeout, sb_q.size());
                continue;
            end
            e = sb_q.pop_front();
            n_tests++;
            if (o.rdata !== e.rdata || o.err !== e.err) begin
                n_fail++;
                $display("FAIL load%0d_data: rdata=%h err=%b want %h %b", k, o.rdata, o.err, e.rdata, e.err);
            end
            n_tests++;
            if (o.rw_cyc != 0 || o.maddr !== e.maddr || o.lat != LAT + 1 || o.stray != 0) begin
                n_fail++;
                $display("FAIL load%0d_access: rw=%0d addr=%h lat=%0d stray=%0d want 0 %h %0d 0",
                         k, o.rw_cyc, o.maddr, o.lat, o.stray, e.maddr, LAT + 1);
            end
        end
    endtask

    task automatic test_reject;
        logic       wens[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [2:0] f3s[4]  = '{3'd3, 3'd4, 3'd5, 3'd7};
        obs_t o;
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            sb_q.push_back('{1'b1, 32'h0, 1'b0, 32'h0, 8'h00, 32'h0, 0});
            run_req(wens[k], f3s[k], 32'h8000_0020, 32'hFFFF_FFFF, 32'h7777_7777, 0, o);
            n_tests++;
            if (o.timeout || sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL reject%0d_timeout: timeout=%b", k, o.timeout);
                continue;
            end
            e = sb_q.pop_front();
            n_tests++;
            if (o.err !== e.err || o.rdata !== e.rdata || o.en_cyc != 0 || o.rw_cyc != 0 || o.lat != 1) begin
                n_fail++;
                $display("FAIL reject%0d: err=%b rdata=%h en=%0d rw=%0d lat=%0d want 1 0 0 0 1",
                         k, o.err, o.rdata, o.en_cyc, o.rw_cyc, o.lat);
            end
        end
    endtask

    task automatic test_misalign;
        obs_t o;
        exp_t e;
`ifdef MISALIGN_TRAP_EN
        sb_q.push_back('{1'b1, 32'h0, 1'b0, 32'h0, 8'h00, 32'h0, 0});
`else
        sb_q.push_back('{1'b0, 32'h0BAD_F00D, 1'b1, 32'h8000_0000, 8'h00, 32'h0, 0});
`endif
        run_req(1'b0, 3'd2, 32'h8000_0002, 32'h0, 32'h0BAD_F00D, 0, o);
        e = sb_q.pop_front();
        n_tests++;
        if (o.timeout || o.err !== e.err || o.rdata !== e.rdata || (o.en_cyc != 0) !== e.acc ||
            (e.acc && o.maddr !== e.maddr)) begin
            n_fail++;
            $display("FAIL misalign_lw: err=%b rdata=%h en=%0d addr=%h want err=%b rdata=%h acc=%b addr=%h",
                     o.err, o.rdata, o.en_cyc, o.maddr, e.err, e.rdata, e.acc, e.maddr);
        end
`ifdef MISALIGN_TRAP_EN
        sb_q.push_back('{1'b1, 32'h0, 1'b0, 32'h0, 8'h00, 32'h0, 0});
`else
        sb_q.push_back('{1'b0, 32'h0, 1'b1, 32'h8000_0000, 8'h03, 32'h0000_BEEF, 1});
`endif
        run_req(1'b1, 3'd1, 32'h8000_0001, 32'h5555_BEEF, 32'h0, 0, o);
        e = sb_q.pop_front();
        n_tests++;
        if (o.timeout || o.err !== e.err || o.rw_cyc != e.rw ||
            (e.acc && (o.wmask !== e.wmask || o.wdata !== e.wdata || o.maddr !== e.maddr))) begin
            n_fail++;
            $display("FAIL misalign_sh: err=%b rw=%0d wmask=%h wdata=%h want err=%b rw=%0d wmask=%h wdata=%h",
                     o.err, o.rw_cyc, o.wmask, o.wdata, e.err, e.rw, e.wmask, e.wdata);
        end
    endtask

    task automatic test_backpressure;
        obs_t o;
        exp_t e;
        sb_q.push_back('{1'b0, 32'h55AA_33CC, 1'b1, 32'h8000_0008, 8'h00, 32'h0, 0});
        run_req(1'b0, 3'd2, 32'h8000_0008, 32'h0, 32'h55AA_33CC, 3, o);
        e = sb_q.pop_front();
        n_tests++;
        if (o.timeout || o.hold_bad != 0 || o.rdata !== e.rdata || o.ready_after !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure: hold_bad=%0d rdata=%h ready_after=%b want 0 %h 1",
                     o.hold_bad, o.rdata, o.ready_after, e.rdata);
        end
    endtask

    task automatic test_back_to_back;
        obs_t o;
        exp_t e;
        logic        wen;
        logic [2:0]  f3;
        logic [31:0] addr, wd, rd;
        int          hold;
        for (int k = 0; k < 24; k++) begin
            wen  = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            addr = {16'h8000, 16'($urandom)};
            wd   = $urandom;
            rd   = $urandom;
            hold = $urandom_range(0, 2);
            sb_q.push_back(model(wen, f3, addr, wd, rd));
            run_req(wen, f3, addr, wd, rd, hold, o);
            e = sb_q.pop_front();
            n_tests++;
            if (o.timeout || o.err !== e.err || o.rdata !== e.rdata || o.hold_bad != 0 || o.stray != 0) begin
                n_fail++;
                $display("FAIL b2b%0d_resp: wen=%b f3=%0d addr=%h err=%b rdata=%h want %b %h (hold_bad=%0d stray=%0d)",
                         k, wen, f3, addr, o.err, o.rdata, e.err, e.rdata, o.hold_bad, o.stray);
            end
            n_tests++;
            if (o.en_cyc != (e.acc ? LAT : 0) || o.rw_cyc != e.rw || o.lat != (e.acc ? LAT + 1 : 1) ||
                (e.acc && o.maddr !== e.maddr) ||
                (e.rw == 1 && (o.wmask !== e.wmask || o.wdata !== e.wdata))) begin
                n_fail++;
                $display("FAIL b2b%0d_mem: en=%0d rw=%0d lat=%0d addr=%h wmask=%h wdata=%h want acc=%b rw=%0d addr=%h wmask=%h wdata=%h",
                         k, o.en_cyc, o.rw_cyc, o.lat, o.maddr, o.wmask, o.wdata,
                         e.acc, e.rw, e.maddr, e.wmask, e.wdata);
            end
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clock);
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_idle: req_ready=%b want 1", req_ready);
        end
        req_valid = 1'b1; req_wen = 1'b1; req_funct3 = 3'd2;
        req_addr = 32'h8000_0010; req_wdata = 32'h1357_9BDF;
        @(negedge clock);
        req_valid = 1'b0;
        n_tests++;
        if (mem_en !== 1'b1 || mem_memRW !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_access: en=%b rw=%b want 1 1", mem_en, mem_memRW);
        end
        #1 reset_n = 1'b0;
        #1;
        n_tests++;
        if (mem_en !== 1'b0 || mem_memRW !== 1'b0 || mem_wmask !== 8'h00) begin
            n_fail++;
            $display("FAIL rstmid_abort: en=%b rw=%b wmask=%h want 0 0 00", mem_en, mem_memRW, mem_wmask);
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        n_tests++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_en !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_idle_after: ready=%b rv=%b en=%b want 1 0 0", req_ready, resp_valid, mem_en);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_store();
        test_load();
        test_reject();
        test_misalign();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
